hwpe_stream_tcdm_rr_arbiter: RTL and testbench

- Shares one TCDM port (req/gnt/add/wen/be/data, r_data/r_valid) between NB_IN requesting TCDM masters.
- Arbitration is round-robin.
- Responses return in order. A FIFO of requester IDs routes each r_valid back to the requester that issued the request.
- Sits between HWPE streamer/source/sink TCDM masters and the cluster interconnect port.

---
 rtl/hwpe_stream_tcdm_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_hwpe_stream_tcdm_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among NB_IN masters.
// In-order responses are routed back through a FIFO of requester IDs.
module hwpe_stream_tcdm_rr_arbiter #(
  parameter int NB_IN           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic [NB_IN-1:0]      in_req_i,
  input  logic [NB_IN*32-1:0]   in_add_i,
  input  logic [NB_IN-1:0]      in_wen_i,
  input  logic [NB_IN*4-1:0]    in_be_i,
  input  logic [NB_IN*32-1:0]   in_data_i,
  output logic [NB_IN-1:0]      in_gnt_o,
  output logic [NB_IN*32-1:0]   in_r_data_o,
  output logic [NB_IN-1:0]      in_r_valid_o,
  output logic                  out_req_o,
  output logic [31:0]           out_add_o,
  output logic                  out_wen_o,
  output logic [3:0]            out_be_o,
  output logic [31:0]           out_data_o,
  input  logic                  out_gnt_i,
  input  logic [31:0]           out_r_data_i,
  input  logic                  out_r_valid_i
);

  localparam int IDW = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] sel;
  logic           any;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  cnt_q;
  logic           full;
  logic           push;
  logic           pop;
  logic [IDW-1:0] fifo_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_q, wrapping around
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < NB_IN; i++) begin
      if (!any && in_req_i[(int'(rr_q) + i) % NB_IN]) begin
        any = 1'b1;
        sel = IDW'((int'(rr_q) + i) % NB_IN);
      end
    end
  end

  assign full      = (cnt_q == CW'(MAX_OUTSTANDING));
  assign out_req_o = any & ~full;
  assign push      = out_req_o & out_gnt_i;
  assign pop       = out_r_valid_i & (cnt_q != '0);
  assign fifo_head = fifo_q[head_q];

  // Winner's fields onto the shared port, zeroed when idle
  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    if (any) begin
      out_add_o  = in_add_i[32*sel +: 32];
      out_wen_o  = in_wen_i[sel];
      out_be_o   = in_be_i[4*sel +: 4];
      out_data_o = in_data_i[32*sel +: 32];
    end
  end

  // Per-requester grant and response demux
  always_comb begin
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    for (int k = 0; k < NB_IN; k++) begin
      in_gnt_o[k]     = push & (sel == IDW'(k));
      in_r_valid_o[k] = pop & (fifo_head == IDW'(k));
    end
  end

  assign in_r_data_o = {NB_IN{out_r_data_i}};

  // Priority moves past the winner only on a completed handshake
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= (sel == IDW'(NB_IN - 1)) ? '0 : sel + 1'b1;
    end
  end

  // ID FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // ID storage, no reset needed since cnt_q gates every read
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail_q] <= sel;
  end

`ifndef SYNTHESIS
  // Responses arriving with no outstanding ID are dropped
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      assert (!(out_r_valid_i && cnt_q == '0))
        else $warning("r_valid with empty id fifo, response dropped");
    end
  end
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// Directed bench for hwpe_stream_tcdm_rr_arbiter.
// Expected values are hand-computed per vector.
module tb_hwpe_stream_tcdm_rr_arbiter;

  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            clear_i;
  logic [N-1:0]    in_req_i;
  logic [N*32-1:0] in_add_i;
  logic [N-1:0]    in_wen_i;
  logic [N*4-1:0]  in_be_i;
  logic [N*32-1:0] in_data_i;
  logic [N-1:0]    in_gnt_o;
  logic [N*32-1:0] in_r_data_o;
  logic [N-1:0]    in_r_valid_o;
  logic            out_req_o;
  logic [31:0]     out_add_o;
  logic            out_wen_o;
  logic [3:0]      out_be_o;
  logic [31:0]     out_data_o;
  logic            out_gnt_i;
  logic [31:0]     out_r_data_i;
  logic            out_r_valid_i;

  int n_chk  = 0;
  int n_pass = 0;

  hwpe_stream_tcdm_rr_arbiter #(
    .NB_IN(N),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i),
    .clear_i(clear_i),
    .in_req_i(in_req_i),
    .in_add_i(in_add_i),
    .in_wen_i(in_wen_i),
    .in_be_i(in_be_i),
    .in_data_i(in_data_i),
    .in_gnt_o(in_gnt_o),
    .in_r_data_o(in_r_data_o),
    .in_r_valid_o(in_r_valid_o),
    .out_req_o(out_req_o),
    .out_add_o(out_add_o),
    .out_wen_o(out_wen_o),
    .out_be_o(out_be_o),
    .out_data_o(out_data_o),
    .out_gnt_i(out_gnt_i),
    .out_r_data_i(out_r_data_i),
    .out_r_valid_i(out_r_valid_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] lane_add(input int k);
    case (k)
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0200;
      2:       return 32'h0000_1000;
      default: return 32'h0000_0300;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req,
                       input logic gnt,
                       input logic rv);
    in_req_i      = req;
    out_gnt_i     = gnt;
    out_r_valid_i = rv;
    #1;
  endtask

  initial begin
    clear_i       = 1'b1;
    in_req_i      = '0;
    out_gnt_i     = 1'b0;
    out_r_valid_i = 1'b0;
    out_r_data_i  = '0;
    for (int k = 0; k < N; k++) begin
      in_add_i[32*k +: 32]  = lane_add(k);
      in_wen_i[k]           = (k != 1);
      in_be_i[4*k +: 4]     = 4'(1 << k);
      in_data_i[32*k +: 32] = 32'hD000_0000 + 32'(k);
    end
    cyc();
    cyc();
    clear_i = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    check("rst_req", 32'(out_req_o), 32'd0);
    check("rst_gnt", 32'(in_gnt_o), 32'd0);
    check("rst_rvalid", 32'(in_r_valid_o), 32'd0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);
    check("rst_rr", 32'(dut.rr_q), 32'd0);
    check("rst_add", out_add_o, 32'd0);

    // single requester 2, read
    cyc();
    drive(4'b0100, 1'b1, 1'b0);
    check("s_req", 32'(out_req_o), 32'd1);
    check("s_gnt", 32'(in_gnt_o), 32'b0100);
    check("s_add", out_add_o, 32'h0000_1000);
    check("s_wen", 32'(out_wen_o), 32'd1);
    check("s_be", 32'(out_be_o), 32'h4);
    check("s_data", out_data_o, 32'hD000_0002);
    cyc();
    out_r_data_i = 32'hCAFE_0001;
    drive(4'b0000, 1'b0, 1'b1);
    check("s_rr", 32'(dut.rr_q), 32'd3);
    check("s_cnt", 32'(dut.cnt_q), 32'd1);
    check("s_rvalid", 32'(in_r_valid_o), 32'b0100);
    check("s_rdata", in_r_data_o[64 +: 32], 32'hCAFE_0001);
    check("s_idle_add", out_add_o, 32'd0);
    cyc();
    drive(4'b0000, 1'b0, 1'b0);
    check("s_cnt_end", 32'(dut.cnt_q), 32'd0);

    // fairness from rr_q=0
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_r_data_i = 32'hBEEF_0000 + 32'(i);
      drive(4'b1111, 1'b1, i > 0);
      check("f_gnt", 32'(in_gnt_o), 32'(1 << (i % 4)));
      check("f_add", out_add_o, lane_add(i % 4));
      check("f_rvalid", 32'(in_r_valid_o),
            (i > 0) ? 32'(1 << ((i - 1) % 4)) : 32'd0);
      cyc();
    end
    drive(4'b0000, 1'b0, 1'b1);
    check("f_rvalid_last", 32'(in_r_valid_o), 32'b1000);
    check("f_rr", 32'(dut.rr_q), 32'd0);
    cyc();
    drive(4'b0000, 1'b0, 1'b0);
    check("f_cnt", 32'(dut.cnt_q), 32'd0);

    // backpressure, requesters 1 and 3
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 1'b0, 1'b0);
      check("b_req", 32'(out_req_o), 32'd1);
      check("b_add", out_add_o, lane_add(1));
      check("b_gnt", 32'(in_gnt_o), 32'd0);
      check("b_rr", 32'(dut.rr_q), 32'd0);
      cyc();
    end
    drive(4'b1010, 1'b1, 1'b0);
    check("b_gnt1", 32'(in_gnt_o), 32'b0010);
    cyc();
    drive(4'b1000, 1'b1, 1'b1);
    check("b_gnt3", 32'(in_gnt_o), 32'b1000);
    check("b_rv1", 32'(in_r_valid_o), 32'b0010);
    cyc();
    drive(4'b0000, 1'b0, 1'b1);
    check("b_rv3", 32'(in_r_valid_o), 32'b1000);
    cyc();
    drive(4'b0000, 1'b0, 1'b0);
    check("b_cnt", 32'(dut.cnt_q), 32'd0);
    check("b_rr_end", 32'(dut.rr_q), 32'd0);

    // fill the ID FIFO
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 1'b1, 1'b0);
      check("u_gnt", 32'(in_gnt_o), 32'(1 << i));
      cyc();
    end
    drive(4'b1111, 1'b1, 1'b0);
    check("u_full_req", 32'(out_req_o), 32'd0);
    check("u_full_gnt", 32'(in_gnt_o), 32'd0);
    check("u_full_cnt", 32'(dut.cnt_q), 32'd4);
    cyc();
    drive(4'b1111, 1'b1, 1'b1);
    check("u_pop_req", 32'(out_req_o), 32'd0);
    check("u_pop_rv", 32'(in_r_valid_o), 32'b0001);
    cyc();
    drive(4'b1111, 1'b1, 1'b0);
    check("u_re_req", 32'(out_req_o), 32'd1);
    check("u_re_gnt", 32'(in_gnt_o), 32'b0001);
    cyc();
    drive(4'b0000, 1'b0, 1'b1);
    check("u_rv1", 32'(in_r_valid_o), 32'b0010);
    cyc();
    drive(4'b0000, 1'b0, 1'b1);
    check("u_rv2", 32'(in_r_valid_o), 32'b0100);
    cyc();

    // simultaneous push/pop at cnt_q=2 (IDs 3,0 queued, rr_q=1)
    drive(4'b0100, 1'b1, 1'b1);
    check("p_cnt_pre", 32'(dut.cnt_q), 32'd2);
    check("p_gnt", 32'(in_gnt_o), 32'b0100);
    check("p_rv", 32'(in_r_valid_o), 32'b1000);
    cyc();
    drive(4'b0010, 1'b1, 1'b0);
    check("p_cnt", 32'(dut.cnt_q), 32'd2);
    check("p_gnt1", 32'(in_gnt_o), 32'b0010);
    cyc();

    // clear with three outstanding
    drive(4'b0000, 1'b0, 1'b0);
    check("c_cnt_pre", 32'(dut.cnt_q), 32'd3);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0, 1'b1);
      check("c_rv", 32'(in_r_valid_o), 32'd0);
      check("c_cnt", 32'(dut.cnt_q), 32'd0);
      check("c_rr", 32'(dut.rr_q), 32'd0);
      cyc();
    end
    drive(4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
